// File: rtl/pcie_tcap_pkg.sv
// Shared types and helpers for the PCIe TLP capture path: direction codes,
// the 48-bit capture header, arbiter state/grant encodings and the header stamper.
package pcie_tcap_pkg;

    localparam logic [1:0] TCAP_DIR_RX = 2'b01;
    localparam logic [1:0] TCAP_DIR_TX = 2'b10;

    // Header layout, MSB first: direction, reserved (always zero), sequence number.
    typedef struct packed {
        logic [1:0]  dir;
        logic [13:0] rsrv;
        logic [31:0] seq;
    } pcie_tcaphdr_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_PASS = 2'd1,
        ARB_DROP = 2'd2
    } arb_state_e;

    typedef enum logic {
        GNT_RX = 1'b0,
        GNT_TX = 1'b1
    } grant_e;

    function automatic pcie_tcaphdr_t tcap_stamp(input logic [1:0] dir, input logic [31:0] seq);
        pcie_tcaphdr_t hdr;
        hdr.dir  = dir;
        hdr.rsrv = '0;
        hdr.seq  = seq;
        return hdr;
    endfunction

endpackage

// File: rtl/pcie_tcap_rr2.sv
// Two-way round-robin grant picker. Purely combinational; the caller owns
// last_grant and decides when a grant is actually taken.
module pcie_tcap_rr2
    import pcie_tcap_pkg::*;
(
    input  logic [1:0] req_i,
    input  grant_e     last_grant_i,
    output grant_e     grant_o,
    output logic       grant_valid_o
);

    // A lone requester always wins; on a tie the one not served last time wins.
    always_comb begin
        grant_valid_o = |req_i;
        grant_o       = GNT_RX;
        case (req_i)
            2'b10:   grant_o = GNT_TX;
            2'b11:   grant_o = (last_grant_i == GNT_TX) ? GNT_RX : GNT_TX;
            default: grant_o = GNT_RX;
        endcase
    end

endmodule

// File: rtl/pcie_tcap_arbiter.sv
// Packet-granular RX/TX arbiter for the TLP capture stream. Each packet is
// either passed through with a stamped header on its first beat, or swallowed
// and counted when capture is disabled at the time it is granted.
module pcie_tcap_arbiter
    import pcie_tcap_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic              seq_clr,
    input  logic              rx_tvalid,
    output logic              rx_tready,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic [KEEP_W-1:0] rx_tkeep,
    input  logic              rx_tlast,
    input  logic              tx_tvalid,
    output logic              tx_tready,
    input  logic [DATA_W-1:0] tx_tdata,
    input  logic [KEEP_W-1:0] tx_tkeep,
    input  logic              tx_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [KEEP_W-1:0] m_tkeep,
    output logic              m_tlast,
    output logic              m_tuser,
    output logic [47:0]       m_hdr,
    output logic [31:0]       drop_cnt
);

    arb_state_e        state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            last_grant_q, last_grant_d;
    logic              first_q, first_d;
    logic [31:0]       seq_q, seq_d;
    logic [31:0]       drop_cnt_q, drop_cnt_d;

    grant_e            rr_grant;
    logic              rr_valid;

    logic              g_tvalid;
    logic              g_tlast;
    logic              g_tready;
    logic [DATA_W-1:0] g_tdata;
    logic [KEEP_W-1:0] g_tkeep;
    logic [1:0]        g_dir;

    pcie_tcap_rr2 u_rr2 (
        .req_i         ({tx_tvalid, rx_tvalid}),
        .last_grant_i  (last_grant_q),
        .grant_o       (rr_grant),
        .grant_valid_o (rr_valid)
    );

    // Select the currently granted requester's beat and its direction code.
    always_comb begin
        if (grant_q == GNT_TX) begin
            g_tvalid = tx_tvalid;
            g_tdata  = tx_tdata;
            g_tkeep  = tx_tkeep;
            g_tlast  = tx_tlast;
            g_dir    = TCAP_DIR_TX;
        end else begin
            g_tvalid = rx_tvalid;
            g_tdata  = rx_tdata;
            g_tkeep  = rx_tkeep;
            g_tlast  = rx_tlast;
            g_dir    = TCAP_DIR_RX;
        end
    end

    // Next-state and output logic; IDLE and reset present an all-zero interface.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_d      = first_q;
        seq_d        = seq_q;
        drop_cnt_d   = drop_cnt_q;
        g_tready     = 1'b0;
        m_tvalid     = 1'b0;
        m_tdata      = '0;
        m_tkeep      = '0;
        m_tlast      = 1'b0;
        m_tuser      = 1'b0;
        m_hdr        = '0;

        case (state_q)
            ARB_IDLE: begin
                // A clear coinciding with a grant lands first, so that packet is stamped 0.
                if (seq_clr) begin
                    seq_d = '0;
                end
                if (rr_valid) begin
                    grant_d      = rr_grant;
                    last_grant_d = rr_grant;
                    first_d      = 1'b1;
                    state_d      = cap_en ? ARB_PASS : ARB_DROP;
                end
            end
            ARB_PASS: begin
                m_tvalid = g_tvalid;
                g_tready = m_tready;
                m_tdata  = g_tdata;
                m_tkeep  = g_tkeep;
                m_tlast  = g_tlast;
                m_tuser  = first_q;
                m_hdr    = tcap_stamp(g_dir, seq_q);
                if (g_tvalid && m_tready) begin
                    if (first_q) begin
                        seq_d   = seq_q + 32'd1;
                        first_d = 1'b0;
                    end
                    if (g_tlast) begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_DROP: begin
                g_tready = 1'b1;
                if (g_tvalid && g_tlast) begin
                    if (drop_cnt_q != 32'hFFFF_FFFF) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    assign rx_tready = (grant_q == GNT_RX) && g_tready;
    assign tx_tready = (grant_q == GNT_TX) && g_tready;
    assign drop_cnt  = drop_cnt_q;

    // State registers; last_grant resets to TX so RX wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            grant_q      <= GNT_RX;
            last_grant_q <= GNT_TX;
            first_q      <= 1'b0;
            seq_q        <= '0;
            drop_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_q      <= first_d;
            seq_q        <= seq_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_pcie_tcap_arbiter.sv
// Bench for the capture arbiter: per-source expected-beat queues, a running
// sequence/drop model and a monitor that scores every output handshake.
module tb_pcie_tcap_arbiter;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cap_en = 1'b1;
    logic              seq_clr = 1'b0;
    logic              rx_tvalid = 1'b0;
    logic              rx_tready;
    logic [DATA_W-1:0] rx_tdata = '0;
    logic [KEEP_W-1:0] rx_tkeep = '0;
    logic              rx_tlast = 1'b0;
    logic              tx_tvalid = 1'b0;
    logic              tx_tready;
    logic [DATA_W-1:0] tx_tdata = '0;
    logic [KEEP_W-1:0] tx_tkeep = '0;
    logic              tx_tlast = 1'b0;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic [DATA_W-1:0] m_tdata;
    logic [KEEP_W-1:0] m_tkeep;
    logic              m_tlast;
    logic              m_tuser;
    logic [47:0]       m_hdr;
    logic [31:0]       drop_cnt;

    int          vecCnt = 0;
    int          missCnt = 0;
    int          cycleCnt = 0;
    int          readyPct = 100;
    int          txReadyHighs = 0;
    bit          expectNoOut = 1'b0;
    bit          inPkt = 1'b0;
    bit          prevHold = 1'b0;
    int          curSrc = 0;
    logic [31:0] seqModel = '0;
    logic [31:0] dropModel = '0;
    beat_t       expRx[$];
    beat_t       expTx[$];
    int          expDir[$];

    pcie_tcap_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_en    (cap_en),
        .seq_clr   (seq_clr),
        .rx_tvalid (rx_tvalid),
        .rx_tready (rx_tready),
        .rx_tdata  (rx_tdata),
        .rx_tkeep  (rx_tkeep),
        .rx_tlast  (rx_tlast),
        .tx_tvalid (tx_tvalid),
        .tx_tready (tx_tready),
        .tx_tdata  (tx_tdata),
        .tx_tkeep  (tx_tkeep),
        .tx_tlast  (tx_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tuser   (m_tuser),
        .m_hdr     (m_hdr),
        .drop_cnt  (drop_cnt)
    );

    // Free-running clock and a cycle counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Overall time limit so a stuck DUT can never hang the run.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            missCnt++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] expHdr(input int src, input logic [31:0] seq);
        logic [1:0] dir;
        dir = (src == 1) ? 2'b10 : 2'b01;
        return {dir, 14'd0, seq};
    endfunction

    // Downstream ready: random with probability readyPct, updated just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_tready = (readyPct >= 100) ? 1'b1 : ($urandom_range(99) < readyPct);
        end
    end

    // Monitor: scores every output handshake against the per-source queues and
    // the running sequence model; also checks ready exclusivity and valid hold.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                inPkt    = 1'b0;
                prevHold = 1'b0;
            end else begin
                if (tx_tready) txReadyHighs++;
                if (expectNoOut) checkOutput("dropNoValid", 64'(m_tvalid), 64'd0);
                checkOutput("readyExcl", 64'(rx_tready & tx_tready), 64'd0);
                if (prevHold) checkOutput("validHold", 64'(m_tvalid), 64'd1);
                prevHold = m_tvalid && !m_tready;
                if (m_tvalid && m_tready) begin
                    checkOutput("tuserFirst", 64'(m_tuser), 64'(!inPkt));
                    if (!inPkt) begin
                        curSrc = (m_hdr[47:46] == 2'b10) ? 1 : 0;
                        checkOutput("hdr", 64'(m_hdr), 64'(expHdr(curSrc, seqModel)));
                        seqModel = seqModel + 32'd1;
                        if (expDir.size() > 0) checkOutput("grantOrder", 64'(curSrc), 64'(expDir.pop_front()));
                    end
                    if ((curSrc == 0 && expRx.size() == 0) || (curSrc == 1 && expTx.size() == 0)) begin
                        checkOutput("unexpectedBeat", 64'd1, 64'd0);
                    end else begin
                        beat_t e;
                        e = (curSrc == 0) ? expRx.pop_front() : expTx.pop_front();
                        checkOutput("beatData", m_tdata, e.data);
                        checkOutput("beatKeepLast", 64'({m_tkeep, m_tlast}), 64'({e.keep, e.last}));
                    end
                    inPkt = !m_tlast;
                end
            end
        end
    end

    task automatic setSrc(input int src, input logic v, input beat_t b);
        if (src == 0) begin
            rx_tvalid = v;
            rx_tdata  = b.data;
            rx_tkeep  = b.keep;
            rx_tlast  = b.last;
        end else begin
            tx_tvalid = v;
            tx_tdata  = b.data;
            tx_tkeep  = b.keep;
            tx_tlast  = b.last;
        end
    endtask

    // Source driver: nPkts packets (nBeats each, or random 1..6 when 0) with
    // random idle gaps; valid is held until the beat is accepted.
    task automatic applyStimulus(input int src, input int nPkts, input int nBeats,
                                 input int gapPct, input bit pass);
        beat_t b;
        bit    hs;
        int    n;
        int    waitCnt;
        b = '0;
        for (int p = 0; p < nPkts; p++) begin
            n = (nBeats > 0) ? nBeats : int'($urandom_range(6, 1));
            for (int i = 0; i < n; i++) begin
                b.data = {$urandom, $urandom};
                b.keep = (i == n - 1) ? 8'($urandom_range(255, 1)) : 8'hFF;
                b.last = (i == n - 1);
                while ($urandom_range(99) < gapPct) begin
                    setSrc(src, 1'b0, b);
                    @(posedge clk);
                    #1;
                end
                if (pass) begin
                    if (src == 0) expRx.push_back(b);
                    else          expTx.push_back(b);
                end
                setSrc(src, 1'b1, b);
                hs = 1'b0;
                waitCnt = 0;
                while (!hs && waitCnt < 500) begin
                    @(negedge clk);
                    hs = (src == 0) ? (rx_tvalid && rx_tready) : (tx_tvalid && tx_tready);
                    @(posedge clk);
                    #1;
                    waitCnt++;
                end
                if (!hs) begin
                    checkOutput("srcTimeout", 64'd1, 64'd0);
                    setSrc(src, 1'b0, b);
                    return;
                end
            end
        end
        setSrc(src, 1'b0, b);
    endtask

    task automatic checkAllZero();
        checkOutput("rstTvalid", 64'(m_tvalid), 64'd0);
        checkOutput("rstTuser", 64'(m_tuser), 64'd0);
        checkOutput("rstTlast", 64'(m_tlast), 64'd0);
        checkOutput("rstTdata", m_tdata, 64'd0);
        checkOutput("rstTkeep", 64'(m_tkeep), 64'd0);
        checkOutput("rstHdr", 64'(m_hdr), 64'd0);
        checkOutput("rstRxReady", 64'(rx_tready), 64'd0);
        checkOutput("rstTxReady", 64'(tx_tready), 64'd0);
        checkOutput("rstDropCnt", 64'(drop_cnt), 64'd0);
    endtask

    task automatic clearModel();
        seqModel  = '0;
        dropModel = '0;
        expRx.delete();
        expTx.delete();
        expDir.delete();
    endtask

    task automatic doReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkAllZero();
        clearModel();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int wait0;
        bit seen;

        $display("[TB] start");
        doReset();

        // Three 2-beat RX packets: seq 0,1,2 and one arbitration cycle per packet.
        repeat (3) expDir.push_back(0);
        c0 = cycleCnt;
        applyStimulus(0, 3, 2, 0, 1'b1);
        checkOutput("rx3Cycles", 64'(cycleCnt - c0), 64'd9);

        // Both sources continuously valid with single-beat packets: strict alternation from RX.
        doReset();
        repeat (4) begin
            expDir.push_back(0);
            expDir.push_back(1);
        end
        fork
            applyStimulus(0, 4, 1, 0, 1'b1);
            applyStimulus(1, 4, 1, 0, 1'b1);
        join
        checkOutput("altSeq", 64'(seqModel), 64'd8);

        // Sequence wrap: preload the counter to all ones, then two packets.
        @(negedge clk);
        force dut.seq_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.seq_q;
        seqModel = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        applyStimulus(0, 2, 1, 0, 1'b1);
        checkOutput("wrapSeq", 64'(seqModel), 64'd1);

        // Capture disabled: four 3-beat TX packets swallowed at full rate.
        doReset();
        cap_en = 1'b0;
        expectNoOut = 1'b1;
        c0 = cycleCnt;
        applyStimulus(1, 4, 3, 0, 1'b0);
        checkOutput("dropCycles", 64'(cycleCnt - c0), 64'd16);
        dropModel = dropModel + 32'd4;
        checkOutput("dropCnt4", 64'(drop_cnt), 64'(dropModel));

        // Enabling capture mid-packet must not rescue the packet already granted.
        fork
            applyStimulus(1, 1, 3, 0, 1'b0);
            begin
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    seen = tx_tvalid && tx_tready;
                end
                checkOutput("midEnSeen", 64'(seen), 64'd1);
                @(posedge clk);
                #1;
                cap_en = 1'b1;
            end
        join
        @(negedge clk);
        expectNoOut = 1'b0;
        @(posedge clk);
        #1;
        dropModel = dropModel + 32'd1;
        checkOutput("dropCnt5", 64'(drop_cnt), 64'(dropModel));
        expDir.push_back(1);
        applyStimulus(1, 1, 3, 0, 1'b1);

        // seq_clr while a packet is passing is ignored.
        fork
            applyStimulus(0, 1, 6, 0, 1'b1);
            begin
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    seen = m_tvalid;
                end
                @(posedge clk);
                #1;
                seq_clr = 1'b1;
                @(posedge clk);
                #1;
                seq_clr = 1'b0;
            end
        join
        applyStimulus(0, 1, 1, 0, 1'b1);

        // seq_clr in the same cycle as a grant: that packet is stamped 0.
        seqModel = '0;
        seq_clr = 1'b1;
        fork
            applyStimulus(1, 1, 2, 0, 1'b1);
            begin
                @(posedge clk);
                #1;
                seq_clr = 1'b0;
            end
        join
        checkOutput("clrSeq", 64'(seqModel), 64'd1);

        // Random downstream backpressure on a 5-beat RX packet; TX stays idle.
        readyPct = 50;
        wait0 = txReadyHighs;
        c0 = int'(seqModel);
        applyStimulus(0, 1, 5, 0, 1'b1);
        readyPct = 100;
        checkOutput("bpTxReady", 64'(txReadyHighs - wait0), 64'd0);
        checkOutput("bpSeqOnce", 64'(int'(seqModel) - c0), 64'd1);

        // Randomised traffic on both sources with gaps and backpressure.
        readyPct = 70;
        fork
            applyStimulus(0, 15, 0, 30, 1'b1);
            applyStimulus(1, 15, 0, 30, 1'b1);
        join
        readyPct = 100;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rndRxDrained", 64'(expRx.size()), 64'd0);
        checkOutput("rndTxDrained", 64'(expTx.size()), 64'd0);
        checkOutput("rndDropCnt", 64'(drop_cnt), 64'(dropModel));

        // Reset during the second beat of a passing RX packet.
        @(posedge clk);
        #1;
        begin
            beat_t b0;
            beat_t b1;
            b0.data = 64'h0123_4567_89AB_CDEF;
            b0.keep = 8'hFF;
            b0.last = 1'b0;
            b1.data = 64'hFEDC_BA98_7654_3210;
            b1.keep = 8'hFF;
            b1.last = 1'b0;
            expRx.push_back(b0);
            setSrc(0, 1'b1, b0);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            setSrc(0, 1'b1, b1);
            checkOutput("midRstBeat2Valid", 64'(m_tvalid), 64'd1);
            #2;
            rst = 1'b1;
            #1;
            checkAllZero();
            setSrc(0, 1'b0, b1);
        end
        clearModel();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expDir.push_back(0);
        expDir.push_back(1);
        fork
            applyStimulus(0, 1, 2, 0, 1'b1);
            applyStimulus(1, 1, 2, 0, 1'b1);
        join
        checkOutput("postRstSeq", 64'(seqModel), 64'd2);
        checkOutput("postRstDir", 64'(expDir.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
